// File: rtl/ball_motion_ctrl.sv
// Ball position/velocity FSM updated once per frame, plus 20x20 sprite render with 1-clk pixel latency.
// No backpressure: motion advances only on vsync rising edges, and the render path runs every cycle.
module ball_motion_ctrl #(
  parameter int          H_ACT        = 640,
  parameter int          V_ACT        = 480,
  parameter int          BALL_SIZE    = 20,
  parameter int          SPEED        = 2,
  parameter int          SERVE_FRAMES = 60,
  parameter int          PADDLE_H     = 80,
  parameter logic [15:0] KEY_COLOR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        start,
  input  logic        serve_dir,
  input  logic [9:0]  paddle_y,
  output logic [9:0]  rom_x_offset,
  output logic [9:0]  rom_y_offset,
  input  logic [15:0] rom_pixel,
  output logic [15:0] ball_pixel,
  output logic        ball_en,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        miss,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_MOVE = 2'd2, S_MISS = 2'd3} state_t;

  localparam logic [9:0]         CX    = 10'((H_ACT - BALL_SIZE) / 2);
  localparam logic [9:0]         CY    = 10'((V_ACT - BALL_SIZE) / 2);
  localparam logic signed [10:0] X_MAX = 11'(H_ACT - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACT - BALL_SIZE);
  localparam logic signed [10:0] SPD   = 11'(SPEED);
  localparam logic signed [10:0] ZERO  = 11'sd0;
  localparam logic [7:0]         SF    = 8'(SERVE_FRAMES);

  state_t             state;
  logic               vsync_d;
  logic               tick;
  logic [7:0]         cnt;
  logic signed [10:0] dx, dy;
  logic signed [10:0] nx, ny;
  logic               hit;
  logic [10:0]        x_end, y_end;
  logic               in_box;

  assign tick    = vsync & ~vsync_d;
  assign state_o = state;

  assign nx = $signed({1'b0, ball_x}) + dx;
  assign ny = $signed({1'b0, ball_y}) + dy;

  // Paddle overlap uses the pre-move row so a grazing ball is judged where it was drawn.
  assign hit = (({1'b0, ball_y} + 11'(BALL_SIZE)) > {1'b0, paddle_y}) &&
               ({1'b0, ball_y} < ({1'b0, paddle_y} + 11'(PADDLE_H)));

  assign x_end  = {1'b0, ball_x} + 11'(BALL_SIZE);
  assign y_end  = {1'b0, ball_y} + 11'(BALL_SIZE);
  assign in_box = DE && (x_pixel >= ball_x) && ({1'b0, x_pixel} < x_end) &&
                  (y_pixel >= ball_y) && ({1'b0, y_pixel} < y_end);

  assign rom_x_offset = in_box ? (x_pixel - ball_x) : 10'd0;
  assign rom_y_offset = in_box ? (y_pixel - ball_y) : 10'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      vsync_d    <= 1'b0;
      cnt        <= 8'd0;
      ball_x     <= CX;
      ball_y     <= CY;
      dx         <= ZERO;
      dy         <= ZERO;
      miss       <= 1'b0;
      ball_pixel <= 16'h0000;
      ball_en    <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      miss       <= 1'b0;
      ball_pixel <= in_box ? rom_pixel : 16'h0000;
      ball_en    <= in_box && (rom_pixel != KEY_COLOR);

      case (state)
        S_IDLE: begin
          ball_x <= CX;
          ball_y <= CY;
          dx     <= ZERO;
          dy     <= ZERO;
          if (start) begin
            state <= S_SERVE;
            cnt   <= SF;
          end
        end

        S_SERVE: begin
          ball_x <= CX;
          ball_y <= CY;
          if (tick) begin
            if (cnt == 8'd1) begin
              state <= S_MOVE;
              dx    <= serve_dir ? SPD : -SPD;
              dy    <= SPD;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        S_MOVE: begin
          if (tick) begin
            if (ny <= ZERO) begin
              ball_y <= 10'd0;
              dy     <= SPD;
            end else if (ny >= Y_MAX) begin
              ball_y <= Y_MAX[9:0];
              dy     <= -SPD;
            end else begin
              ball_y <= ny[9:0];
            end

            // Miss branch comes last so its recentre overrides the row update above.
            if (nx >= X_MAX) begin
              ball_x <= X_MAX[9:0];
              dx     <= -SPD;
            end else if (nx <= ZERO) begin
              if (hit) begin
                ball_x <= 10'd0;
                dx     <= SPD;
              end else begin
                state  <= S_MISS;
                miss   <= 1'b1;
                ball_x <= CX;
                ball_y <= CY;
                dx     <= ZERO;
                dy     <= ZERO;
                cnt    <= SF;
              end
            end else begin
              ball_x <= nx[9:0];
            end
          end
        end

        S_MISS: begin
          state  <= S_SERVE;
          ball_x <= CX;
          ball_y <= CY;
          dx     <= ZERO;
          dy     <= ZERO;
          cnt    <= SF;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: render window, serve count, wall/paddle bounces, miss, corner, reset.
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        de;
  logic [9:0]  x_pixel, y_pixel;
  logic        start, serve_dir;
  logic [9:0]  paddle_y;
  logic [9:0]  rom_x_offset, rom_y_offset;
  logic [15:0] rom_pixel;
  logic [15:0] ball_pixel;
  logic        ball_en;
  logic [9:0]  ball_x, ball_y;
  logic        miss;
  logic [1:0]  state_o;

  // Second, small-field instance: equal width/height makes the diagonal serve hit a corner quickly.
  logic        s_start;
  logic [9:0]  s_paddle_y = 10'd0;
  logic [15:0] s_rom_pixel = 16'h0000;
  logic [9:0]  s_rom_x_offset, s_rom_y_offset;
  logic [15:0] s_ball_pixel;
  logic        s_ball_en;
  logic [9:0]  s_ball_x, s_ball_y;
  logic        s_miss;
  logic [1:0]  s_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .clk(clk), .reset(reset), .vsync(vsync), .DE(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .start(start), .serve_dir(serve_dir),
    .paddle_y(paddle_y), .rom_x_offset(rom_x_offset), .rom_y_offset(rom_y_offset),
    .rom_pixel(rom_pixel), .ball_pixel(ball_pixel), .ball_en(ball_en),
    .ball_x(ball_x), .ball_y(ball_y), .miss(miss), .state_o(state_o)
  );

  ball_motion_ctrl #(.H_ACT(60), .V_ACT(60), .SERVE_FRAMES(2)) dut_small (
    .clk(clk), .reset(reset), .vsync(vsync), .DE(1'b0),
    .x_pixel(10'd0), .y_pixel(10'd0), .start(s_start), .serve_dir(1'b1),
    .paddle_y(s_paddle_y), .rom_x_offset(s_rom_x_offset), .rom_y_offset(s_rom_y_offset),
    .rom_pixel(s_rom_pixel), .ball_pixel(s_ball_pixel), .ball_en(s_ball_en),
    .ball_x(s_ball_x), .ball_y(s_ball_y), .miss(s_miss), .state_o(s_state_o)
  );

  // Sprite ROM model: transparent where (ox+oy)%7==3, otherwise a nonzero address-derived colour.
  function automatic logic [15:0] rom_fn(input int ox, input int oy);
    if ((ox + oy) % 7 == 3) return 16'h0000;
    return 16'(32'h8000 | (oy << 10) | ox);
  endfunction

  always_comb rom_pixel = rom_fn(int'(rom_x_offset), int'(rom_y_offset));

  always @(posedge clk) if (miss === 1'b1) miss_cnt <= miss_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, 32'(ball_x), 32'(ex));
    chk({tag, "_y"}, 32'(ball_y), 32'(ey));
  endtask

  // One pixel through the render path, with the ball expected at (bx,by).
  task automatic pix(input int x, input int y, input logic d, input int bx, input int by);
    bit inb;
    int ox, oy;
    logic [15:0] ep;
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    de      = d;
    inb = d && x >= bx && x < bx + 20 && y >= by && y < by + 20;
    ox  = inb ? x - bx : 0;
    oy  = inb ? y - by : 0;
    ep  = inb ? rom_fn(ox, oy) : 16'h0000;
    #1;
    chk("rom_x_off", 32'(rom_x_offset), 32'(ox));
    chk("rom_y_off", 32'(rom_y_offset), 32'(oy));
    step();
    chk("ball_pixel", 32'(ball_pixel), 32'(ep));
    chk("ball_en", 32'(ball_en), 32'(ep != 16'h0000));
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; de = 1'b0; x_pixel = '0; y_pixel = '0;
    start = 1'b0; serve_dir = 1'b1; paddle_y = 10'd200; s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_state", 32'(state_o), 32'd0);
    chk_pos("rst", 310, 230);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_en", 32'(ball_en), 32'd0);
    chk("rst_pixel", 32'(ball_pixel), 32'd0);
    chk("s_rst_x", 32'(s_ball_x), 32'd20);
    chk("s_rst_y", 32'(s_ball_y), 32'd20);

    // Start coinciding with a frame tick: SERVE entered, that tick not counted.
    s_start = 1'b1; vsync = 1'b1;
    step();
    s_start = 1'b0; vsync = 1'b0;
    chk("s_serve", 32'(s_state_o), 32'd1);
    step();
    tick();
    chk("s_serve_cnt", 32'(s_state_o), 32'd1);
    tick();
    chk("s_move", 32'(s_state_o), 32'd2);
    ticks(9);
    chk("s_pre_x", 32'(s_ball_x), 32'd38);
    chk("s_pre_y", 32'(s_ball_y), 32'd38);
    tick();
    chk("s_corner_x", 32'(s_ball_x), 32'd40);
    chk("s_corner_y", 32'(s_ball_y), 32'd40);
    tick();
    chk("s_after_x", 32'(s_ball_x), 32'd38);
    chk("s_after_y", 32'(s_ball_y), 32'd38);
    chk("idle_hold", 32'(state_o), 32'd0);
    chk_pos("idle_pos", 310, 230);

    // Render window around the centred ball, including every box edge.
    for (int y = 225; y <= 255; y++)
      for (int x = 300; x <= 340; x++)
        pix(x, y, 1'b1, 310, 230);
    pix(315, 235, 1'b0, 310, 230);
    pix(0, 0, 1'b1, 310, 230);
    pix(639, 479, 1'b1, 310, 230);
    de = 1'b0;

    // Serve: 60 ticks to launch.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("serve", 32'(state_o), 32'd1);
    ticks(59);
    chk("serve_59", 32'(state_o), 32'd1);
    tick();
    chk("move_60", 32'(state_o), 32'd2);
    chk_pos("launch", 310, 230);
    tick();
    chk_pos("k1", 312, 232);
    ticks(113);
    chk_pos("k114", 538, 458);
    tick();
    chk_pos("bottom", 540, 460);
    tick();
    chk_pos("k116", 542, 458);
    ticks(39);
    chk_pos("right", 620, 380);
    tick();
    chk_pos("k156", 618, 378);
    ticks(308);
    chk_pos("k464", 2, 238);

    // Paddle hit with ball_y just inside the paddle's bottom edge (238 < 159+80).
    paddle_y = 10'd159;
    tick();
    chk_pos("hit", 0, 240);
    chk("hit_state", 32'(state_o), 32'd2);
    chk("hit_nomiss", 32'(miss_cnt), 32'd0);
    tick();
    chk_pos("k466", 2, 242);
    ticks(618);
    chk_pos("k1084", 2, 362);

    // Miss with ball bottom exactly at the paddle top (362+20 > 382 is false).
    paddle_y = 10'd382;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    chk("miss_state", 32'(state_o), 32'd3);
    chk("miss_pulse", 32'(miss), 32'd1);
    chk_pos("miss_ctr", 310, 230);
    step();
    chk("miss_to_serve", 32'(state_o), 32'd1);
    chk("miss_drop", 32'(miss), 32'd0);
    chk("miss_count", 32'(miss_cnt), 32'd1);
    step();

    // Start during SERVE must not reload or disturb the count.
    ticks(30);
    start = 1'b1;
    step();
    start = 1'b0;
    ticks(29);
    chk("reserve_59", 32'(state_o), 32'd1);
    tick();
    chk("remove_60", 32'(state_o), 32'd2);
    tick();
    chk_pos("relaunch", 312, 232);

    // Render while moving: top-left texel and just outside the box.
    pix(312, 232, 1'b1, 312, 232);
    pix(311, 232, 1'b1, 312, 232);
    pix(331, 251, 1'b1, 312, 232);
    de = 1'b0;

    // Reset mid-MOVE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk_pos("mid_rst", 310, 230);
    chk("mid_rst_miss", 32'(miss_cnt), 32'd1);
    tick();
    chk("idle_tick", 32'(state_o), 32'd0);
    chk_pos("idle_tick", 310, 230);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
